// File: rtl/block_memory_responder.sv
// Memory-side end of the cache block interface.
// Whole-block reads/writes served after a fixed latency.
module block_memory_responder #(
  parameter int cache_block   = 512,
  parameter int main_mem_size = 8388608,
  parameter int read_latency  = 4,
  parameter int write_latency = 4,
  parameter int count_width   = 32,
  localparam int depth  = main_mem_size / cache_block,
  localparam int addr_w = $clog2(depth)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   read_in,
  input  logic                   write_in,
  input  logic [addr_w-1:0]      address_in,
  input  logic [cache_block-1:0] data_in,
  output logic [cache_block-1:0] data_out,
  output logic                   busy_out,
  output logic                   valid_out,
  output logic                   done_out,
  output logic                   error_out,
  output logic [count_width-1:0] read_count_out,
  output logic [count_width-1:0] write_count_out
);

  localparam int max_lat =
    (read_latency > write_latency) ? read_latency : write_latency;
  localparam int cnt_w = (max_lat > 1) ? $clog2(max_lat) : 1;

  localparam logic [cnt_w-1:0] rd_load = cnt_w'(read_latency - 1);
  localparam logic [cnt_w-1:0] wr_load = cnt_w'(write_latency - 1);
  localparam logic [count_width-1:0] cnt_max = '1;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [cnt_w-1:0]       lat_cnt;
  logic [addr_w-1:0]      addr_q;
  logic [cache_block-1:0] wdata_q;
  logic [cache_block-1:0] mem [depth];

  logic take_rd;
  logic take_wr;
  logic reject;
  logic fin_rd;
  logic fin_wr;
  logic busy;
  logic lat_zero;

  assign lat_zero = (lat_cnt == '0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take_rd) begin
          state_nx = READ_WAIT;
        end else if (take_wr) begin
          state_nx = WRITE_WAIT;
        end
      end
      READ_WAIT: begin
        if (lat_zero) state_nx = IDLE;
      end
      WRITE_WAIT: begin
        if (lat_zero) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Requests are only looked at in IDLE; anything while busy is dropped.
  always_comb begin
    take_rd = 1'b0;
    take_wr = 1'b0;
    reject  = 1'b0;
    fin_rd  = 1'b0;
    fin_wr  = 1'b0;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        take_rd = read_in & ~write_in;
        take_wr = write_in & ~read_in;
        reject  = read_in & write_in;
      end
      READ_WAIT: begin
        busy   = 1'b1;
        fin_rd = lat_zero;
      end
      WRITE_WAIT: begin
        busy   = 1'b1;
        fin_wr = lat_zero;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign busy_out = busy;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lat_cnt   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      done_out  <= 1'b0;
      error_out <= 1'b0;
    end else begin
      valid_out <= fin_rd;
      done_out  <= fin_wr;
      error_out <= reject;
      if (take_rd || take_wr) begin
        addr_q  <= address_in;
        lat_cnt <= take_rd ? rd_load : wr_load;
      end else if (busy && !lat_zero) begin
        lat_cnt <= lat_cnt - cnt_w'(1);
      end
      if (take_wr) wdata_q <= data_in;
      if (fin_rd) data_out <= mem[addr_q];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      read_count_out  <= '0;
      write_count_out <= '0;
    end else begin
      if (take_rd && read_count_out != cnt_max) begin
        read_count_out <= read_count_out + count_width'(1);
      end
      if (take_wr && write_count_out != cnt_max) begin
        write_count_out <= write_count_out + count_width'(1);
      end
    end
  end

  // Storage survives reset; an aborted write never reaches fin_wr.
  always_ff @(posedge clk_in) begin
    if (fin_wr) mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_block_memory_responder.sv
// Bench for block_memory_responder: directed plus randomized
// traffic against an associative-array memory model.
module tb_block_memory_responder;

  logic         clk;
  logic         rst_n;
  logic         rd, wr;
  logic [13:0]  addr;
  logic [511:0] din, dout;
  logic         busy, valid, done, err;
  logic [31:0]  rcnt, wcnt;

  logic         b_rst_n;
  logic         b_rd, b_wr;
  logic [3:0]   b_addr;
  logic [511:0] b_din, b_dout;
  logic         b_busy, b_valid, b_done, b_err;
  logic [1:0]   b_rcnt, b_wcnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [511:0] mdl [int];
  logic [31:0]  exp_rd, exp_wr;

  block_memory_responder dut (
    .clk_in(clk), .rst_n_in(rst_n), .read_in(rd), .write_in(wr),
    .address_in(addr), .data_in(din), .data_out(dout),
    .busy_out(busy), .valid_out(valid), .done_out(done),
    .error_out(err), .read_count_out(rcnt), .write_count_out(wcnt)
  );

  block_memory_responder #(
    .main_mem_size(512 * 16), .read_latency(1),
    .write_latency(1), .count_width(2)
  ) dut_b (
    .clk_in(clk), .rst_n_in(b_rst_n), .read_in(b_rd),
    .write_in(b_wr), .address_in(b_addr), .data_in(b_din),
    .data_out(b_dout), .busy_out(b_busy), .valid_out(b_valid),
    .done_out(b_done), .error_out(b_err),
    .read_count_out(b_rcnt), .write_count_out(b_wcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] mget(input int a);
    if (mdl.exists(a)) return mdl[a];
    return '0;
  endfunction

  task automatic rd1(input logic [13:0] a, output logic [511:0] d,
                     output int lat, output logic bt, output logic bf);
    rd = 1'b1; wr = 1'b0; addr = a; din = rnd512();
    tick();
    bt = busy;
    rd = 1'b0; addr = 14'($urandom);
    lat = -1; d = '0; bf = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (valid) begin
        lat = k; d = dout; bf = busy;
        break;
      end
    end
    if (exp_rd != 32'hFFFF_FFFF) exp_rd++;
  endtask

  task automatic wr1(input logic [13:0] a, input logic [511:0] v,
                     output int lat, output logic bt, output logic bf);
    wr = 1'b1; rd = 1'b0; addr = a; din = v;
    tick();
    bt = busy;
    wr = 1'b0; addr = 14'($urandom); din = rnd512();
    lat = -1; bf = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        lat = k; bf = busy;
        break;
      end
    end
    mdl[int'(a)] = v;
    if (exp_wr != 32'hFFFF_FFFF) exp_wr++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd = 0; wr = 0; addr = '0; din = '0;
    b_rst_n = 1'b0; b_rd = 0; b_wr = 0; b_addr = '0; b_din = '0;
    exp_rd = 0; exp_wr = 0;
    #12;
    total_cnt++;
    if ({busy, valid, done, err} !== 4'b0 || dout !== '0) begin
      $display("FAIL reset_outputs got %b/%h want 0", {busy, valid, done, err}, dout);
    end else pass_cnt++;
    total_cnt++;
    if (rcnt !== 0 || wcnt !== 0) begin
      $display("FAIL reset_counts got %0d/%0d want 0/0", rcnt, wcnt);
    end else pass_cnt++;
    rst_n = 1'b1; b_rst_n = 1'b1;
    tick();
    total_cnt++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle got busy=%b want 0", busy);
    end else pass_cnt++;
  endtask

  task automatic test_read_zero();
    logic [511:0] d; int lat; logic bt, bf;
    rd1(14'h0005, d, lat, bt, bf);
    total_cnt++;
    if (bt !== 1'b1) begin
      $display("FAIL read0_busy_T got %b want 1", bt);
    end else pass_cnt++;
    total_cnt++;
    if (lat != 4 || bf !== 1'b0) begin
      $display("FAIL read0_latency got %0d busy=%b want 4 busy=0", lat, bf);
    end else pass_cnt++;
    total_cnt++;
    if (d !== '0) begin
      $display("FAIL read0_data got %h want 0", d);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (valid !== 1'b0) begin
      $display("FAIL read0_pulse got valid=%b want 0", valid);
    end else pass_cnt++;
  endtask

  task automatic test_ignore_busy();
    logic [511:0] d; int lat; logic bt, bf;
    rd = 1'b1; addr = 14'h0002;
    tick();
    rd = 1'b0; wr = 1'b1; addr = 14'h0001; din = rnd512();
    if (exp_rd != 32'hFFFF_FFFF) exp_rd++;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (valid) begin lat = k; break; end
    end
    wr = 1'b0;
    tick();
    total_cnt++;
    if (lat != 4 || busy !== 1'b0 || wcnt !== exp_wr) begin
      $display("FAIL ignore_write got lat=%0d busy=%b wcnt=%0d want 4/0/%0d",
               lat, busy, wcnt, exp_wr);
    end else pass_cnt++;
    rd1(14'h0001, d, lat, bt, bf);
    total_cnt++;
    if (d !== mget(1) || lat != 4) begin
      $display("FAIL ignore_read got %h lat=%0d want %h lat=4", d, lat, mget(1));
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_write_read();
    logic [511:0] d, pat; int lat; logic bt, bf;
    pat = {64{8'hA5}};
    wr1(14'h3FFF, pat, lat, bt, bf);
    total_cnt++;
    if (bt !== 1'b1 || lat != 4 || bf !== 1'b0) begin
      $display("FAIL write_done got bt=%b lat=%0d bf=%b want 1/4/0", bt, lat, bf);
    end else pass_cnt++;
    tick();
    rd1(14'h3FFF, d, lat, bt, bf);
    total_cnt++;
    if (d !== pat || lat != 4) begin
      $display("FAIL raw_data got %h lat=%0d want %h lat=4", d, lat, pat);
    end else pass_cnt++;
    total_cnt++;
    if (rcnt !== exp_rd || wcnt !== exp_wr) begin
      $display("FAIL raw_counts got %0d/%0d want %0d/%0d", rcnt, wcnt, exp_rd, exp_wr);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_illegal();
    rd = 1'b1; wr = 1'b1; addr = 14'($urandom); din = rnd512();
    tick();
    total_cnt++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL illegal_err got err=%b busy=%b want 1/0", err, busy);
    end else pass_cnt++;
    rd = 1'b0; wr = 1'b0;
    tick();
    total_cnt++;
    if (err !== 1'b0 || busy !== 1'b0 || rcnt !== exp_rd || wcnt !== exp_wr) begin
      $display("FAIL illegal_after got err=%b busy=%b cnt=%0d/%0d want 0/0/%0d/%0d",
               err, busy, rcnt, wcnt, exp_rd, exp_wr);
    end else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [511:0] d; int lat; logic bt, bf, seen;
    wr = 1'b1; addr = 14'h0010; din = rnd512();
    tick();
    wr = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_rd = 0; exp_wr = 0;
    total_cnt++;
    if ({busy, valid, done, err} !== 4'b0 || dout !== '0 ||
        rcnt !== 0 || wcnt !== 0) begin
      $display("FAIL abort_reset got %b dout=%h cnt=%0d/%0d want all 0",
               {busy, valid, done, err}, dout, rcnt, wcnt);
    end else pass_cnt++;
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen |= done;
    end
    total_cnt++;
    if (seen !== 1'b0) begin
      $display("FAIL abort_done got %b want 0", seen);
    end else pass_cnt++;
    rd1(14'h0010, d, lat, bt, bf);
    total_cnt++;
    if (d !== mget(16) || lat != 4) begin
      $display("FAIL abort_data got %h lat=%0d want %h lat=4", d, lat, mget(16));
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [511:0] d, v; int lat; logic bt, bf;
    logic [13:0] pool [6];
    logic [13:0] a;
    pool[0] = 14'h0000; pool[1] = 14'h3FFF; pool[2] = 14'h0010;
    for (int i = 3; i < 6; i++) pool[i] = 14'($urandom);
    for (int n = 0; n < 40; n++) begin
      a = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1) begin
        v = rnd512();
        wr1(a, v, lat, bt, bf);
        total_cnt++;
        if (bt !== 1'b1 || lat != 4 || bf !== 1'b0 || wcnt !== exp_wr) begin
          $display("FAIL rand_write[%0d] got bt=%b lat=%0d bf=%b wcnt=%0d want 1/4/0/%0d",
                   n, bt, lat, bf, wcnt, exp_wr);
        end else pass_cnt++;
      end else begin
        rd1(a, d, lat, bt, bf);
        total_cnt++;
        if (d !== mget(int'(a)) || bt !== 1'b1 || lat != 4 || rcnt !== exp_rd) begin
          $display("FAIL rand_read[%0d] a=%h got %h lat=%0d rcnt=%0d want %h lat=4 rcnt=%0d",
                   n, a, d, lat, rcnt, mget(int'(a)), exp_rd);
        end else pass_cnt++;
      end
      tick();
      total_cnt++;
      if (valid !== 1'b0 || done !== 1'b0) begin
        $display("FAIL rand_pulse[%0d] got valid=%b done=%b want 0/0", n, valid, done);
      end else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    b_rst_n = 1'b0;
    #2 b_rst_n = 1'b1;
    b_rd = 1'b1; b_addr = 4'($urandom);
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = (k % 2 == 0);
      total_cnt++;
      if (b_valid !== e || (e && b_dout !== '0)) begin
        $display("FAIL b2b_valid[%0d] got %b dout=%h want %b dout=0", k, b_valid, b_dout, e);
      end else pass_cnt++;
    end
    b_rd = 1'b0;
    tick();
    total_cnt++;
    if (b_rcnt !== 2'd3 || {b_err, b_done} !== 2'b0) begin
      $display("FAIL b2b_sat got rcnt=%0d err/done=%b want 3/00", b_rcnt, {b_err, b_done});
    end else pass_cnt++;
  endtask

  task automatic test_saturation();
    int got;
    b_rst_n = 1'b0;
    #2 b_rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      b_rd = 1'b1; b_addr = 4'($urandom);
      tick();
      b_rd = 1'b0;
      got = -1;
      for (int k = 1; k <= 10; k++) begin
        if (b_valid) begin got = k; break; end
        tick();
      end
      total_cnt++;
      if (got < 0 || int'(b_rcnt) != ((n < 3) ? n : 3) || b_wcnt !== 2'd0) begin
        $display("FAIL sat_count[%0d] got rcnt=%0d wcnt=%0d seen=%0d want %0d/0",
                 n, b_rcnt, b_wcnt, got, (n < 3) ? n : 3);
      end else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_ignore_busy();
    test_write_read();
    test_illegal();
    test_reset_abort();
    test_random();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
